// File: rtl/vga_plot_arbiter_pkg.sv
// rtl/vga_plot_arbiter_pkg.sv - shared types and constants for the VGA plot arbiter
//
// Purpose: state encoding for the arbiter/clear sequencer, default geometry
// (160x120, 9-bit colour, three requesters) and an index-width helper used
// by the arbiter and the round-robin sub-block.
// Ports: none (package).

package vga_plot_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_XW      = 8;
  localparam int DEF_YW      = 7;
  localparam int DEF_CW      = 9;
  localparam int DEF_H_RES   = 160;
  localparam int DEF_V_RES   = 120;

  // Width of an index into n requesters; never zero so a 1-requester
  // instance still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_arbiter.sv
// rtl/vga_plot_arbiter_rr_arbiter.sv - combinational round-robin grant selector
//
// Purpose: given a request vector and the index of the last winner, grant the
// first requester found searching ptr+1, ptr+2, ... ptr+N (mod N). Purely
// combinational; the caller owns the pointer register.
// Ports:
//   i_req    [N-1:0]   request vector
//   i_ptr    [IW-1:0]  last granted index (must be < N)
//   i_enable           0 forces no grant
//   o_grant  [N-1:0]   one-hot grant
//   o_idx    [IW-1:0]  encoded index of the grant (0 when none)
//   o_valid            a grant was issued

module vga_plot_arbiter_rr_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // One extra bit so ptr+k never overflows before the modulo fold.
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_cand = w_sum[IW-1:0];
      if (i_enable && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

  assign o_valid = w_found;

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin sharing of the VGA pixel port plus screen clear
//
// Purpose: NUM_REQ drawing engines share one registered pixel-write port, one
// pixel per cycle, under round-robin arbitration. A clear sequencer raster-fills
// the frame with one colour and owns the port exclusively while it runs.
// Ports:
//   CLOCK_50                    clock, rising edge
//   Resetn                      asynchronous active-low reset
//   req_valid [NUM_REQ]         requester has a pixel pending
//   req_x/req_y/req_color       packed per-requester pixel, slice i = [i*W +: W]
//   req_ready [NUM_REQ]         one-hot grant (combinational)
//   clear_start, clear_color    start a full-screen clear with this colour
//   clear_done                  1-cycle pulse once the last clear pixel has been shown
//   busy                        high while the clear owns the port
//   VGA_X, VGA_Y, VGA_COLOR     registered pixel to the VGA adapter
//   plot                        registered write strobe
//
// Clear timeline (clear_start accepted in cycle N):
//   N+1 .. N+H*V  plot=1, raster pixels (0,0) .. (H-1,V-1); busy=1
//   N+H*V+1       clear_done=1, plot=0, busy=0, requesters may be granted
// To reach the first plot in N+1, the accept cycle itself loads pixel (0,0)
// and the counters start at the second pixel; the one-cycle DONE state is the
// cycle in which the last pixel is on the port. H_RES must be at least 2.

module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int CW      = DEF_CW,
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES
) (
  input  logic                  CLOCK_50,
  input  logic                  Resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*YW-1:0] req_y,
  input  logic [NUM_REQ*CW-1:0] req_color,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  clear_start,
  input  logic [CW-1:0]         clear_color,
  output logic                  clear_done,
  output logic                  busy,
  output logic [XW-1:0]         VGA_X,
  output logic [YW-1:0]         VGA_Y,
  output logic [CW-1:0]         VGA_COLOR,
  output logic                  plot
);

  localparam int            IW     = idx_w(NUM_REQ);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_t r_state;
  state_t w_next_state;

  logic [IW-1:0] r_ptr;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [CW-1:0] r_fill;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_color;
  logic          r_plot;
  logic          r_done;

  logic               w_arb_en;
  logic               w_start;
  logic               w_last_pix;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_gvalid;
  logic [XW-1:0]      w_sel_x;
  logic [YW-1:0]      w_sel_y;
  logic [CW-1:0]      w_sel_c;

  vga_plot_arbiter_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_arb_en),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_valid  (w_gvalid)
  );

  assign w_sel_x = req_x[int'(w_idx)*XW +: XW];
  assign w_sel_y = req_y[int'(w_idx)*YW +: YW];
  assign w_sel_c = req_color[int'(w_idx)*CW +: CW];

  assign w_last_pix = (r_cx == X_LAST) && (r_cy == Y_LAST);

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // clear_start in IDLE pre-empts every requester in the same cycle, so the
  // arbiter is only enabled when no clear is being accepted.
  always_comb begin
    w_next_state = r_state;
    w_arb_en     = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          w_start      = 1'b1;
          w_next_state = S_CLEAR;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_last_pix) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_ptr   <= IW'(NUM_REQ - 1);
      r_cx    <= '0;
      r_cy    <= '0;
      r_fill  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_plot  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_fill  <= clear_color;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= clear_color;
            r_plot  <= 1'b1;
            r_cx    <= XW'(1);
            r_cy    <= '0;
          end else if (w_gvalid) begin
            r_x     <= w_sel_x;
            r_y     <= w_sel_y;
            r_color <= w_sel_c;
            r_plot  <= 1'b1;
            r_ptr   <= w_idx;
          end else begin
            r_plot <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_x     <= r_cx;
          r_y     <= r_cy;
          r_color <= r_fill;
          r_plot  <= 1'b1;
          // Counters park at (0,0) after the last pixel rather than stepping
          // past the frame, so full-width coordinate fields never wrap.
          if (w_last_pix) begin
            r_cx <= '0;
            r_cy <= '0;
          end else if (r_cx == X_LAST) begin
            r_cx <= '0;
            r_cy <= r_cy + YW'(1);
          end else begin
            r_cx <= r_cx + XW'(1);
          end
        end
        S_DONE: begin
          r_plot <= 1'b0;
        end
        default: begin
          r_plot <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign busy       = (r_state != S_IDLE);
  assign clear_done = r_done;
  assign VGA_X      = r_x;
  assign VGA_Y      = r_y;
  assign VGA_COLOR  = r_color;
  assign plot       = r_plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter

module tb_vga_plot_arbiter;

  localparam int N  = 3;
  localparam int H  = 160;
  localparam int V  = 120;
  localparam int HV = H * V;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rv;
  logic [7:0] rx [3];
  logic [6:0] ry [3];
  logic [8:0] rc [3];
  logic [23:0] px;
  logic [20:0] py;
  logic [26:0] pc;
  logic       crstart;
  logic [8:0] ccol;

  logic [2:0] req_ready;
  logic       clear_done;
  logic       busy;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [8:0] VGA_COLOR;
  logic       plot;

  always #10 clk = ~clk;

  always_comb begin
    px = {rx[2], rx[1], rx[0]};
    py = {ry[2], ry[1], ry[0]};
    pc = {rc[2], rc[1], rc[0]};
  end

  vga_plot_arbiter dut (
    .CLOCK_50    (clk),
    .Resetn      (rst_n),
    .req_valid   (rv),
    .req_x       (px),
    .req_y       (py),
    .req_color   (pc),
    .req_ready   (req_ready),
    .clear_start (crstart),
    .clear_color (ccol),
    .clear_done  (clear_done),
    .busy        (busy),
    .VGA_X       (VGA_X),
    .VGA_Y       (VGA_Y),
    .VGA_COLOR   (VGA_COLOR),
    .plot        (plot)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: clear is tracked as a timeline anchored at its accept
  // cycle; arbitration as "search upward from the last winner".
  int         m_cyc = 0;
  int         m_t0  = -1;
  int         m_ptr = N - 1;
  logic [8:0] m_fill;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [8:0] e_c;
  logic       e_plot;
  logic [2:0] m_last_ready;

  logic [2:0] obs_ready;
  logic       obs_plot;
  logic       obs_done;
  logic [7:0] obs_x;
  logic [6:0] obs_y;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
    logic [7:0] exp_x;
    logic [6:0] exp_y;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic bit in_win(input int t);
    return (m_t0 >= 0) && (t >= m_t0) && (t <= m_t0 + HV);
  endfunction

  function automatic logic [2:0] mdl_ready(input logic [2:0] v, input logic cs, input int t);
    logic [2:0] g;
    bit found;
    g = 3'b000;
    found = 0;
    if (!in_win(t) && !cs) begin
      for (int d = 1; d <= N; d++) begin
        int c;
        c = (m_ptr + d) % N;
        if (!found && v[c]) begin
          found = 1;
          g[c] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic run_cycle();
    logic [2:0] er;
    int t;
    int k;
    t = m_cyc;
    #1;
    er = mdl_ready(rv, crstart, t);
    chk("req_ready", {29'd0, req_ready}, {29'd0, er});
    chk("plot", {31'd0, plot}, {31'd0, e_plot});
    chk("vga_x", {24'd0, VGA_X}, {24'd0, e_x});
    chk("vga_y", {25'd0, VGA_Y}, {25'd0, e_y});
    chk("vga_color", {23'd0, VGA_COLOR}, {23'd0, e_c});
    chk("busy", {31'd0, busy}, {31'd0, (m_t0 >= 0 && t >= m_t0 + 1 && t <= m_t0 + HV)});
    chk("clear_done", {31'd0, clear_done}, {31'd0, (m_t0 >= 0 && t == m_t0 + HV + 1)});
    obs_ready    = req_ready;
    obs_plot     = plot;
    obs_done     = clear_done;
    obs_x        = VGA_X;
    obs_y        = VGA_Y;
    m_last_ready = er;
    if (crstart && !in_win(t)) begin
      m_t0 = t; m_fill = ccol;
      e_x = 8'd0; e_y = 7'd0; e_c = ccol; e_plot = 1'b1;
    end else if (m_t0 >= 0 && t >= m_t0 + 1 && t <= m_t0 + HV - 1) begin
      k = t - m_t0;
      e_x = 8'(k % H); e_y = 7'(k / H); e_c = m_fill; e_plot = 1'b1;
    end else if (m_t0 >= 0 && t == m_t0 + HV) begin
      e_plot = 1'b0;
    end else if (er != 3'b000) begin
      for (int i = 0; i < N; i++) begin
        if (er[i]) begin
          e_x = rx[i]; e_y = ry[i]; e_c = rc[i]; m_ptr = i;
        end
      end
      e_plot = 1'b1;
    end else begin
      e_plot = 1'b0;
    end
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset asynchronously mid-low-phase.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vga_x", {24'd0, VGA_X}, 32'd0);
    chk("rst_vga_y", {25'd0, VGA_Y}, 32'd0);
    chk("rst_vga_color", {23'd0, VGA_COLOR}, 32'd0);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    m_t0 = -1; m_ptr = N - 1;
    e_x = '0; e_y = '0; e_c = '0; e_plot = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_fixed_data();
    rx[0] = 8'd3;   ry[0] = 7'd4;  rc[0] = 9'h011;
    rx[1] = 8'd100; ry[1] = 7'd50; rc[1] = 9'h0AA;
    rx[2] = 8'd5;   ry[2] = 7'd7;  rc[2] = 9'h1FF;
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", m_cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int plots;
    int dones;
    bit pend [3];

    tbl[0]  = '{3'b111, 3'b001, 8'd3,   7'd4};
    tbl[1]  = '{3'b111, 3'b010, 8'd100, 7'd50};
    tbl[2]  = '{3'b111, 3'b100, 8'd5,   7'd7};
    tbl[3]  = '{3'b111, 3'b001, 8'd3,   7'd4};
    tbl[4]  = '{3'b111, 3'b010, 8'd100, 7'd50};
    tbl[5]  = '{3'b111, 3'b100, 8'd5,   7'd7};
    tbl[6]  = '{3'b111, 3'b001, 8'd3,   7'd4};
    tbl[7]  = '{3'b111, 3'b010, 8'd100, 7'd50};
    tbl[8]  = '{3'b111, 3'b100, 8'd5,   7'd7};
    tbl[9]  = '{3'b100, 3'b100, 8'd5,   7'd7};
    tbl[10] = '{3'b100, 3'b100, 8'd5,   7'd7};
    tbl[11] = '{3'b010, 3'b010, 8'd100, 7'd50};
    tbl[12] = '{3'b011, 3'b001, 8'd3,   7'd4};
    tbl[13] = '{3'b011, 3'b010, 8'd100, 7'd50};
    tbl[14] = '{3'b000, 3'b000, 8'd0,   7'd0};
    tbl[15] = '{3'b101, 3'b100, 8'd5,   7'd7};

    rst_n = 1'b1; rv = 3'b000; crstart = 1'b0; ccol = 9'h000;
    set_fixed_data();
    e_x = '0; e_y = '0; e_c = '0; e_plot = 1'b0; m_fill = '0;
    @(negedge clk);
    async_reset();

    // Directed arbitration vectors
    for (int r = 0; r < 16; r++) begin
      rv = tbl[r].valid;
      run_cycle();
      chk("tbl_ready", {29'd0, obs_ready}, {29'd0, tbl[r].exp_ready});
      if (r > 0 && tbl[r-1].exp_ready != 3'b000) begin
        chk("tbl_plot", {31'd0, obs_plot}, 32'd1);
        chk("tbl_vga_x", {24'd0, obs_x}, {24'd0, tbl[r-1].exp_x});
        chk("tbl_vga_y", {25'd0, obs_y}, {25'd0, tbl[r-1].exp_y});
      end
    end

    // Random requesters that hold valid and data until accepted
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          rx[i] = 8'($urandom_range(0, H - 1));
          ry[i] = 7'($urandom_range(0, V - 1));
          rc[i] = 9'($urandom);
        end
      end
      rv = {pend[2], pend[1], pend[0]};
      run_cycle();
      for (int i = 0; i < N; i++) if (m_last_ready[i]) pend[i] = 0;
    end

    // Clear in black with requester 1 waiting throughout
    set_fixed_data();
    rv = 3'b000;
    run_cycle();
    rv = 3'b010; ccol = 9'h000; crstart = 1'b1;
    run_cycle();
    crstart = 1'b0;
    plots = 0; dones = 0;
    for (int i = 1; i <= HV + 1; i++) begin
      run_cycle();
      if (obs_plot) plots++;
      if (obs_done) dones++;
      if (i == HV) begin
        chk("clear_last_x", {24'd0, obs_x}, 32'd159);
        chk("clear_last_y", {25'd0, obs_y}, 32'd119);
      end
      if (i == HV + 1) chk("grant_after_clear", {29'd0, obs_ready}, 32'b010);
    end
    chk("clear_plot_count", plots, HV);
    chk("clear_done_count", dones, 1);
    rv = 3'b000;
    run_cycle();

    // Clear re-pulsed mid-run; the re-pulse must be ignored
    rv = 3'b111; ccol = 9'h155; crstart = 1'b1;
    run_cycle();
    crstart = 1'b0;
    plots = 0; dones = 0;
    for (int i = 1; i <= HV + 1; i++) begin
      crstart = (i == 100);
      ccol = (i == 100) ? 9'h0F0 : 9'h155;
      run_cycle();
      if (obs_plot) plots++;
      if (obs_done) dones++;
    end
    crstart = 1'b0;
    chk("repulse_plot_count", plots, HV);
    chk("repulse_done_count", dones, 1);
    rv = 3'b000;
    run_cycle();

    // Reset in the middle of a clear, then a fresh clear from (0,0)
    ccol = 9'h0C3; crstart = 1'b1;
    run_cycle();
    crstart = 1'b0;
    for (int i = 1; i <= 5000; i++) run_cycle();
    async_reset();
    rv = 3'b111;
    #1;
    chk("grant_after_reset", {29'd0, req_ready}, 32'b001);
    run_cycle();
    rv = 3'b000;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      if (obs_done) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    ccol = 9'h1C7; crstart = 1'b1;
    run_cycle();
    crstart = 1'b0;
    run_cycle();
    chk("restart_plot", {31'd0, obs_plot}, 32'd1);
    chk("restart_x", {24'd0, obs_x}, 32'd0);
    chk("restart_y", {25'd0, obs_y}, 32'd0);
    for (int i = 2; i <= HV + 2; i++) run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
